// File: rtl/icache_line_filler_pkg.sv
// ---------------------------------------------------------------------------
// icache_line_filler_pkg
//   Shared definitions for the instruction-cache line filler: the default
//   line geometry (kept in step with the cache), the RAM read latency and the
//   fill FSM state type.
//   No ports; imported by the interface, the filler and its line assembler.
// ---------------------------------------------------------------------------
package icache_line_filler_pkg;

  // log2 of the line size in bytes; the cache uses the same value
  localparam int DEFAULT_BLOCK_WIDTH = 4;

  // cycles between presenting a RAM address and its data on ramDataIn
  localparam int RAM_READ_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FETCH = 2'd2,
    ST_DONE  = 2'd3
  } fill_state_e;

  function automatic int blockSize(input int blockWidth);
    return 1 << blockWidth;
  endfunction

endpackage

// File: rtl/icache_line_filler_if.sv
// ---------------------------------------------------------------------------
// icache_line_filler_if
//   Bundles the filler's cache-side, arbiter-side and RAM-side signals.
//   master : the line filler (drives request, RAM address and fill result)
//   slave  : the environment (cache + memory arbiter + RAM)
//   Signals:
//     missIn/missAddrIn/flushIn  cache miss, missing address, pipeline flush
//     grantIn/reqOut             RAM port arbitration
//     ramAddrOut/ramDataIn       8-bit synchronous RAM read bus
//     fillValidOut/fillAddrOut/fillDataOut  completed line to the cache
//     busyOut                    filler is not idle
// ---------------------------------------------------------------------------
interface icache_line_filler_if
  import icache_line_filler_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
);
  localparam int BLOCK_SIZE = blockSize(BLOCK_WIDTH);

  logic                      missIn;
  logic [31:0]               missAddrIn;
  logic                      flushIn;
  logic                      grantIn;
  logic                      reqOut;
  logic [31:0]               ramAddrOut;
  logic [7:0]                ramDataIn;
  logic                      fillValidOut;
  logic [31-BLOCK_WIDTH:0]   fillAddrOut;
  logic [BLOCK_SIZE*8-1:0]   fillDataOut;
  logic                      busyOut;

  modport master (
    input  missIn, missAddrIn, flushIn, grantIn, ramDataIn,
    output reqOut, ramAddrOut, fillValidOut, fillAddrOut, fillDataOut, busyOut
  );

  modport slave (
    output missIn, missAddrIn, flushIn, grantIn, ramDataIn,
    input  reqOut, ramAddrOut, fillValidOut, fillAddrOut, fillDataOut, busyOut
  );

endinterface

// File: rtl/icache_line_filler_line_assembler.sv
// ---------------------------------------------------------------------------
// line_assembler
//   BLOCK_SIZE x 8-bit register file that collects RAM bytes into one cache
//   line. One byte is written per cycle at byte index idx_i when we_i is high.
//   Contents persist until overwritten, so the last completed line stays
//   visible on line_o until the next fill writes into it.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset (clears the line)
//     idx_i           byte index inside the line
//     byte_i          byte to write
//     we_i            byte write enable
//     line_o          flat line, byte k at bits [8k+7:8k]
// ---------------------------------------------------------------------------
module line_assembler
  import icache_line_filler_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [BLOCK_WIDTH-1:0]                  idx_i,
  input  logic [7:0]                              byte_i,
  input  logic                                    we_i,
  output logic [blockSize(BLOCK_WIDTH)*8-1:0]     line_o
);
  localparam int BLOCK_SIZE = blockSize(BLOCK_WIDTH);

  logic [7:0] mem_q [BLOCK_SIZE];

  // Byte-wide storage; reset clears the whole line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      mem_q[idx_i] <= byte_i;
    end
  end

  // Flatten the byte array into the line bus.
  for (genvar k = 0; k < BLOCK_SIZE; k++) begin : g_flat
    assign line_o[8*k +: 8] = mem_q[k];
  end

endmodule

// File: rtl/icache_line_filler.sv
// ---------------------------------------------------------------------------
// icache_line_filler
//   Miss-driven line fill engine. On a miss it requests the RAM port, reads
//   the line byte by byte (one address per cycle, data one cycle later),
//   assembles it and pulses fillValidOut for one cycle with the line address.
//   A flush in REQ or FETCH abandons the fill without a pulse.
//   Ports:
//     clkIn     system clock
//     resetIn   asynchronous active-low reset
//     bus       icache_line_filler_if master modport (miss, flush, grant,
//               RAM bus, fill result, busy)
// ---------------------------------------------------------------------------
module icache_line_filler
  import icache_line_filler_pkg::*;
#(
  parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
) (
  input  logic                 clkIn,
  input  logic                 resetIn,
  icache_line_filler_if.master bus
);
  localparam int BLOCK_SIZE = blockSize(BLOCK_WIDTH);

  // Counter runs one step past the last byte to catch the final RAM read.
  localparam logic [BLOCK_WIDTH:0]   CNT_LAST          = (BLOCK_WIDTH+1)'(BLOCK_SIZE);
  localparam logic [BLOCK_WIDTH:0]   CNT_FIRST_CAPTURE = (BLOCK_WIDTH+1)'(RAM_READ_LATENCY);
  localparam logic [BLOCK_WIDTH-1:0] IDX_LAG           = BLOCK_WIDTH'(RAM_READ_LATENCY);

  fill_state_e               state_q, state_d;
  logic [BLOCK_WIDTH:0]      cnt_q, cnt_d;
  logic [31-BLOCK_WIDTH:0]   fillAddr_q, fillAddr_d;

  logic                      req;
  logic                      fillValid;
  logic [31:0]               ramAddr;
  logic                      wrEn;
  logic [BLOCK_WIDTH-1:0]    wrIdx;
  logic [BLOCK_SIZE*8-1:0]   lineData;

  // State, byte counter and latched line address.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fillAddr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fillAddr_q <= fillAddr_d;
    end
  end

  // Next state and outputs. The byte read at count c arrives at count c+1,
  // so capture lags the issued address by the RAM read latency; the byte
  // index is the low counter bits, so addresses never carry into the line.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fillAddr_d = fillAddr_q;
    req        = 1'b0;
    fillValid  = 1'b0;
    ramAddr    = '0;
    wrEn       = 1'b0;
    wrIdx      = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.missIn && !bus.flushIn) begin
          fillAddr_d = (32-BLOCK_WIDTH)'(bus.missAddrIn >> BLOCK_WIDTH);
          state_d    = ST_REQ;
        end
      end

      ST_REQ: begin
        req = 1'b1;
        if (bus.flushIn) begin
          state_d = ST_IDLE;
        end else if (bus.grantIn) begin
          cnt_d   = '0;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        req = 1'b1;
        if (cnt_q < CNT_LAST) begin
          ramAddr = {fillAddr_q, cnt_q[BLOCK_WIDTH-1:0]};
        end
        // a byte arriving in the flush cycle belongs to an abandoned fill
        if (cnt_q >= CNT_FIRST_CAPTURE && !bus.flushIn) begin
          wrEn  = 1'b1;
          wrIdx = cnt_q[BLOCK_WIDTH-1:0] - IDX_LAG;
        end
        if (bus.flushIn) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + (BLOCK_WIDTH+1)'(1);
        end
      end

      ST_DONE: begin
        // line is complete; a flush here cannot invalidate it
        fillValid = 1'b1;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  line_assembler #(
    .BLOCK_WIDTH (BLOCK_WIDTH)
  ) u_line_assembler (
    .clk_i  (clkIn),
    .rst_ni (resetIn),
    .idx_i  (wrIdx),
    .byte_i (bus.ramDataIn),
    .we_i   (wrEn),
    .line_o (lineData)
  );

  assign bus.reqOut       = req;
  assign bus.ramAddrOut   = ramAddr;
  assign bus.fillValidOut = fillValid;
  assign bus.fillAddrOut  = fillAddr_q;
  assign bus.fillDataOut  = lineData;
  assign bus.busyOut      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icache_line_filler.sv
// ---------------------------------------------------------------------------
// tb_icache_line_filler
//   Self-checking bench for icache_line_filler. A behavioural RAM returns
//   (address low byte XOR salt); the expected line is byte k = RAM[base+k].
//   Fills are driven cycle by cycle from a table of hand-picked vectors and
//   then from random transactions, with timing expectations derived from the
//   grant cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_icache_line_filler;
  import icache_line_filler_pkg::*;

  localparam int BW = 4;
  localparam int BS = 1 << BW;

  logic clkIn = 1'b0;
  logic resetIn;

  always #5 clkIn = ~clkIn;

  icache_line_filler_if #(.BLOCK_WIDTH(BW)) bus ();

  icache_line_filler #(.BLOCK_WIDTH(BW)) dut (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int pulseTally = 0;

  logic [BS*8-1:0] lastLine;
  logic            lineKnown;
  logic [31-BW:0]  lastFillAddr;

  // Behavioural synchronous RAM: address seen in a cycle, data next cycle.
  logic [7:0]  ramSalt = 8'h00;
  logic [31:0] ramAddrSeen = 32'h0;

  function automatic logic [7:0] ramByte(input logic [31:0] a, input logic [7:0] s);
    return a[7:0] ^ s;
  endfunction

  always @(negedge clkIn) ramAddrSeen = bus.ramAddrOut;
  always @(posedge clkIn) bus.ramDataIn <= ramByte(ramAddrSeen, ramSalt);

  // Reference: the line is BS consecutive RAM bytes from the aligned base.
  function automatic logic [BS*8-1:0] expectedLine(input logic [31:0] a, input logic [7:0] s);
    logic [BS*8-1:0] l;
    logic [31:0] base;
    l = '0;
    base = a & ~32'(BS - 1);
    for (int k = 0; k < BS; k++) begin
      l[8*k +: 8] = ramByte(base + 32'(k), s);
    end
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkCycle(input string tag, input logic eReq, input logic eBusy,
                            input logic eValid, input logic [31:0] eRam);
    if (bus.fillValidOut === 1'b1) pulseTally++;
    checkOutput({tag, ".reqOut"},       128'(bus.reqOut),       128'(eReq));
    checkOutput({tag, ".busyOut"},      128'(bus.busyOut),      128'(eBusy));
    checkOutput({tag, ".fillValidOut"}, 128'(bus.fillValidOut), 128'(eValid));
    checkOutput({tag, ".ramAddrOut"},   128'(bus.ramAddrOut),   128'(eRam));
  endtask

  task automatic checkHeld(input string tag);
    checkOutput({tag, ".fillAddrOut"}, 128'(bus.fillAddrOut), 128'(lastFillAddr));
    if (lineKnown) checkOutput({tag, ".fillDataOut"}, 128'(bus.fillDataOut), 128'(lastLine));
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic miss, input logic [31:0] addr,
                               input logic flush, input logic grant);
    @(posedge clkIn);
    #1;
    bus.missIn     = miss;
    bus.missAddrIn = addr;
    bus.flushIn    = flush;
    bus.grantIn    = grant;
    @(negedge clkIn);
  endtask

  task automatic idleCycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
      checkCycle(tag, 1'b0, 1'b0, 1'b0, 32'h0);
    end
  endtask

  // flushPhase: 0 none, 1 in the grant cycle of REQ, 2 in FETCH at count flushCnt
  task automatic runFill(input logic [31:0] addr, input int gap, input int grantDelay,
                         input int flushPhase, input int flushCnt, input logic [7:0] salt,
                         input logic missInDone, input logic [31-BW:0] eFillAddr,
                         input int ePulses);
    int   startTally;
    logic fl;
    logic flushed;
    logic [31:0] base;
    startTally = pulseTally;
    flushed    = 1'b0;
    base       = {addr[31:BW], {BW{1'b0}}};
    ramSalt    = salt;

    for (int i = 0; i < gap; i++) begin
      applyStimulus(1'b0, $urandom, 1'b0, 1'b0);
      checkCycle("gap", 1'b0, 1'b0, 1'b0, 32'h0);
      checkHeld("gap");
    end

    applyStimulus(1'b1, addr, 1'b0, 1'b0);
    checkCycle("miss", 1'b0, 1'b0, 1'b0, 32'h0);
    checkHeld("miss");

    for (int i = 0; i <= grantDelay; i++) begin
      fl = (flushPhase == 1 && i == grantDelay);
      applyStimulus(1'b0, $urandom, fl, i == grantDelay);
      checkCycle("req", 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("req.fillAddrOut", 128'(bus.fillAddrOut), 128'(eFillAddr));
      if (lineKnown) checkOutput("req.fillDataHeld", 128'(bus.fillDataOut), 128'(lastLine));
      if (fl) flushed = 1'b1;
    end

    if (!flushed) begin
      for (int k = 0; k <= BS; k++) begin
        fl = (flushPhase == 2 && k == flushCnt);
        applyStimulus(1'b0, $urandom, fl, 1'b1);
        checkCycle("fetch", 1'b1, 1'b1, 1'b0, (k < BS) ? base + 32'(k) : 32'h0);
        if (k < 2 && lineKnown)
          checkOutput("fetch.fillDataHeld", 128'(bus.fillDataOut), 128'(lastLine));
        if (fl) begin
          flushed   = 1'b1;
          lineKnown = 1'b0;
          break;
        end
      end
    end

    lastFillAddr = eFillAddr;
    if (flushed) begin
      // where the pulse would have been, nothing may appear
      idleCycles("postflush", BS + 3);
    end else begin
      applyStimulus(missInDone, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      checkCycle("done", 1'b0, 1'b1, 1'b1, 32'h0);
      checkOutput("done.fillAddrOut", 128'(bus.fillAddrOut), 128'(eFillAddr));
      checkOutput("done.fillDataOut", 128'(bus.fillDataOut), 128'(expectedLine(addr, salt)));
      lastLine  = expectedLine(addr, salt);
      lineKnown = 1'b1;
    end
    checkOutput("pulseCount", 128'(pulseTally - startTally), 128'(ePulses));
  endtask

  typedef struct {
    logic [31:0]    addr;
    int             gap;
    int             grantDelay;
    int             flushPhase;
    int             flushCnt;
    logic [7:0]     salt;
    logic           missInDone;
    logic [31-BW:0] expFillAddr;
    int             expPulses;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          fp;

    // basic, delayed grant, address run, flush then refill, REQ flush, top of map,
    // flush at last count, flush at first count, back-to-back refill
    vecs.push_back('{32'h00001234, 2, 0, 0,  0, 8'h00, 1'b0, 28'h0000123, 1});
    vecs.push_back('{32'h00005678, 1, 5, 0,  0, 8'hA5, 1'b1, 28'h0000567, 1});
    vecs.push_back('{32'h000010FC, 0, 0, 0,  0, 8'h00, 1'b0, 28'h000010F, 1});
    vecs.push_back('{32'hDEADBEEF, 1, 2, 2,  7, 8'h3C, 1'b0, 28'hDEADBEE, 0});
    vecs.push_back('{32'h00002000, 0, 0, 0,  0, 8'h5A, 1'b0, 28'h0000200, 1});
    vecs.push_back('{32'h12345678, 2, 1, 1,  0, 8'h11, 1'b0, 28'h1234567, 0});
    vecs.push_back('{32'hFFFFFFF0, 0, 3, 0,  0, 8'hC3, 1'b1, 28'hFFFFFFF, 1});
    vecs.push_back('{32'h0000ABCD, 1, 0, 2, 16, 8'h77, 1'b0, 28'h0000ABC, 0});
    vecs.push_back('{32'h0000BEE0, 0, 0, 2,  0, 8'h01, 1'b0, 28'h0000BEE, 0});
    vecs.push_back('{32'h00001234, 0, 4, 0,  0, 8'h00, 1'b0, 28'h0000123, 1});

    bus.missIn     = 1'b0;
    bus.missAddrIn = 32'h0;
    bus.flushIn    = 1'b0;
    bus.grantIn    = 1'b0;
    resetIn        = 1'b0;

    // reset state
    #12;
    checkOutput("reset.reqOut",       128'(bus.reqOut),       128'(0));
    checkOutput("reset.fillValidOut", 128'(bus.fillValidOut), 128'(0));
    checkOutput("reset.ramAddrOut",   128'(bus.ramAddrOut),   128'(0));
    checkOutput("reset.fillAddrOut",  128'(bus.fillAddrOut),  128'(0));
    checkOutput("reset.fillDataOut",  128'(bus.fillDataOut),  128'(0));
    checkOutput("reset.busyOut",      128'(bus.busyOut),      128'(0));
    @(negedge clkIn);
    resetIn      = 1'b1;
    lastLine     = '0;
    lineKnown    = 1'b1;
    lastFillAddr = '0;

    // miss together with flush in IDLE is not accepted
    applyStimulus(1'b1, 32'h00004444, 1'b1, 1'b0);
    checkCycle("missflush", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkCycle("missflushNext", 1'b0, 1'b0, 1'b0, 32'h0);
    checkHeld("missflushNext");

    foreach (vecs[i]) begin
      runFill(vecs[i].addr, vecs[i].gap, vecs[i].grantDelay, vecs[i].flushPhase,
              vecs[i].flushCnt, vecs[i].salt, vecs[i].missInDone,
              vecs[i].expFillAddr, vecs[i].expPulses);
    end

    // reset asserted in the middle of FETCH clears everything at once
    ramSalt = 8'h9C;
    applyStimulus(1'b1, 32'h00003000, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    checkOutput("midfetch.busyOut", 128'(bus.busyOut), 128'(1));
    #2;
    resetIn = 1'b0;
    #1;
    checkOutput("asyncReset.reqOut",      128'(bus.reqOut),      128'(0));
    checkOutput("asyncReset.busyOut",     128'(bus.busyOut),     128'(0));
    checkOutput("asyncReset.ramAddrOut",  128'(bus.ramAddrOut),  128'(0));
    checkOutput("asyncReset.fillAddrOut", 128'(bus.fillAddrOut), 128'(0));
    checkOutput("asyncReset.fillDataOut", 128'(bus.fillDataOut), 128'(0));
    @(negedge clkIn);
    resetIn      = 1'b1;
    lastLine     = '0;
    lineKnown    = 1'b1;
    lastFillAddr = '0;
    begin
      int t0;
      t0 = pulseTally;
      idleCycles("afterReset", BS + 3);
      checkOutput("afterReset.pulseCount", 128'(pulseTally - t0), 128'(0));
    end

    // randomized transactions against the reference
    for (int n = 0; n < 30; n++) begin
      a  = $urandom;
      fp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      runFill(a, $urandom_range(0, 3), $urandom_range(0, 4), fp, $urandom_range(0, BS),
              8'($urandom), 1'($urandom_range(0, 1)), a[31:BW], (fp == 0) ? 1 : 0);
    end

    idleCycles("final", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
